// File: rtl/debounce_enable.sv
// debounce_enable
//    Conditions a raw push-button and raw slide switches for the D latch and
//    register stages. The button and switches are each synchronised through
//    two flops, the button is debounced by a counter-driven FSM, and the
//    switch word is captured at the moment a press is accepted.
//
//    Optional feature macro: AUTOREPEAT_EN
//       defined   : while the button stays held, en_pulse repeats every
//                   REPEAT_CYCLES+1 cycles and data_q is re-captured each time.
//       undefined : exactly one en_pulse per accepted press.
//
//    Ports
//       clk       in   1      system clock, rising edge
//       rst_n     in   1      asynchronous active-low reset
//       btn_in    in   1      raw button (asynchronous, bouncy)
//       data_in   in   WIDTH  raw switches (asynchronous)
//       en_level  out  1      debounced button level, drives latch E
//       en_pulse  out  1      one-cycle strobe per accepted press / repeat
//       data_q    out  WIDTH  switch word captured at acceptance, drives latch D
//       busy      out  1      high while qualifying an edge
//
//    state     | meaning
//    ----------+------------------------------------------------------------
//    IDLE      | button released and debounced, waiting for a high sample
//    ARMING    | button seen high, counting stable high samples
//    HELD      | press accepted, en_level high
//    RELEASING | button seen low while held, counting stable low samples

module debounce_enable #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             en_level,
   output logic             en_pulse,
   output logic [WIDTH-1:0] data_q,
   output logic             busy
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      RELEASING = 2'd3
   } state_t;

   logic             btn_m;
   logic             btn_s;
   logic [WIDTH-1:0] data_m;
   logic [WIDTH-1:0] data_s;

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic             en_level_nx;
   logic             en_pulse_nx;
   logic [WIDTH-1:0] data_q_nx;

   // Two-flop synchronisers; the FSM only ever looks at btn_s / data_s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_m  <= 1'b0;
         btn_s  <= 1'b0;
         data_m <= '0;
         data_s <= '0;
      end else begin
         btn_m  <= btn_in;
         btn_s  <= btn_m;
         data_m <= data_in;
         data_s <= data_m;
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int            RW      = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_ONE = RW'(1);

   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt_nx;
      end
   end
`else
   // REPEAT_CYCLES only matters to the auto-repeat build; referenced here so
   // the parameter list stays identical between builds.
   if (REPEAT_CYCLES < 1) begin : g_repeat_unused
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         en_level <= 1'b0;
         en_pulse <= 1'b0;
         data_q   <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         en_level <= en_level_nx;
         en_pulse <= en_pulse_nx;
         data_q   <= data_q_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      en_level_nx = en_level;
      en_pulse_nx = 1'b0;
      data_q_nx   = data_q;
`ifdef AUTOREPEAT_EN
      rcnt_nx     = rcnt;
`endif

      unique case (state)
         IDLE: begin
            if (btn_s) begin
               state_nx = ARMING;
               cnt_nx   = CNT_ONE;
            end else begin
               cnt_nx   = '0;
            end
         end

         ARMING: begin
            if (!btn_s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx    = HELD;
               cnt_nx      = '0;
               data_q_nx   = data_s;
               en_level_nx = 1'b1;
               en_pulse_nx = 1'b1;
`ifdef AUTOREPEAT_EN
               rcnt_nx     = '0;
`endif
            end else begin
               // Saturating increment: the counter must never wrap.
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            end
         end

         HELD: begin
            if (!btn_s) begin
               state_nx = RELEASING;
               cnt_nx   = CNT_ONE;
`ifdef AUTOREPEAT_EN
               rcnt_nx  = '0;
`endif
            end else begin
`ifdef AUTOREPEAT_EN
               if (rcnt == RPT_MAX) begin
                  en_pulse_nx = 1'b1;
                  data_q_nx   = data_s;
                  rcnt_nx     = '0;
               end else begin
                  rcnt_nx     = rcnt + RPT_ONE;
               end
`endif
            end
         end

         RELEASING: begin
`ifdef AUTOREPEAT_EN
            rcnt_nx = '0;
`endif
            if (btn_s) begin
               // Release bounce: back to HELD silently, no pulse, no capture.
               state_nx = HELD;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx    = IDLE;
               cnt_nx      = '0;
               en_level_nx = 1'b0;
            end else begin
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            end
         end

         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign busy = (state == ARMING) || (state == RELEASING);

endmodule

// File: tb/tb_debounce_enable.sv
// Bench for debounce_enable with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, WIDTH=8.
// Directed per-cycle vector table, hand sequences for reset and auto-repeat,
// then random button/switch activity checked against a run-length model.

module tb_debounce_enable;

   localparam int D = 4;
   localparam int R = 8;
   localparam int W = 8;

`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         btn_in;
   logic [W-1:0] data_in;
   logic         en_level;
   logic         en_pulse;
   logic [W-1:0] data_q;
   logic         busy;

   debounce_enable #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_in  (btn_in),
      .data_in (data_in),
      .en_level(en_level),
      .en_pulse(en_pulse),
      .data_q  (data_q),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: the button level flips once a run of D+1 consecutive
   // synchronised samples disagrees with it. Samples reach the model two
   // edges after btn_in/data_in are driven.
   typedef struct {
      logic         sb1, sb2;
      logic [W-1:0] sd1, sd2;
      logic         lvl;
      int           run;
      int           hc;
      logic         pulse;
      logic [W-1:0] dq;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t mstep(mstate_t c, logic b, logic [W-1:0] d);
      mstate_t      n;
      logic         s;
      logic [W-1:0] ds;
      n  = c;
      s  = c.sb2;
      ds = c.sd2;
      n.sb2   = c.sb1;
      n.sb1   = b;
      n.sd2   = c.sd1;
      n.sd1   = d;
      n.pulse = 1'b0;
      if (s != c.lvl) begin
         n.run = c.run + 1;
         if (n.run == D + 1) begin
            n.lvl = s;
            n.run = 0;
            if (s) begin
               n.pulse = 1'b1;
               n.dq    = ds;
               n.hc    = 0;
            end
         end
      end else begin
         n.run = 0;
      end
      if (AR && c.lvl) begin
         if (!s || c.run != 0) begin
            n.hc = 0;
         end else begin
            n.hc = c.hc + 1;
            if (n.hc == R + 1) begin
               n.pulse = 1'b1;
               n.dq    = ds;
               n.hc    = 0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{default: 0};
      else        m <= mstep(m, btn_in, data_in);
   end

   typedef struct {
      logic         b;
      logic [W-1:0] d;
      logic         lvl;
      logic         pls;
      logic [W-1:0] dq;
      logic         bsy;
   } vec_t;

   vec_t tbl[$];

   task automatic add_run(input int n, input logic b, input logic [W-1:0] d,
                          input logic lvl, input logic pls, input logic [W-1:0] dq,
                          input logic bsy);
      vec_t v;
      v = '{b: b, d: d, lvl: lvl, pls: pls, dq: dq, bsy: bsy};
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic expect_pulse_at6(input string tag);
      for (int e = 0; e < 10; e++) begin
         step();
         check({tag, "_pulse"}, 32'(en_pulse), 32'(e == 6));
      end
      check({tag, "_level"}, 32'(en_level), 32'(1));
   endtask

   initial begin
      int           off;
      bit           found;
      int           run_left;
      logic         cur;

      rst_n   = 1'b0;
      btn_in  = 1'b0;
      data_in = '0;
      repeat (2) @(negedge clk);
      check("rst_level", 32'(en_level), 32'(0));
      check("rst_pulse", 32'(en_pulse), 32'(0));
      check("rst_data",  32'(data_q),   32'(0));
      check("rst_busy",  32'(busy),     32'(0));
      rst_n = 1'b1;
      repeat (4) step();

      // Clean press (A5), release bounce, full release.
      add_run(2, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
      add_run(4, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
      add_run(1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0);
      add_run(3, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
      add_run(2, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
      add_run(2, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
      add_run(2, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
      add_run(2, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
      add_run(4, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
      add_run(2, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
      // Press bounce (3C), then switches change to FF while held.
      add_run(2, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0);
      add_run(1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1);
      add_run(1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1);
      add_run(1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0);
      add_run(4, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1);
      add_run(1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0);
      add_run(2, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0);
      add_run(2, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0);
      add_run(4, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1);
      add_run(2, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h3C, 1'b0);

      foreach (tbl[i]) begin
         btn_in  = tbl[i].b;
         data_in = tbl[i].d;
         step();
         check($sformatf("vec%0d_level", i), 32'(en_level), 32'(tbl[i].lvl));
         check($sformatf("vec%0d_pulse", i), 32'(en_pulse), 32'(tbl[i].pls));
         check($sformatf("vec%0d_data",  i), 32'(data_q),   32'(tbl[i].dq));
         check($sformatf("vec%0d_busy",  i), 32'(busy),     32'(tbl[i].bsy));
      end

      // Reset mid-cycle while HELD, button kept high.
      data_in = 8'h5A;
      btn_in  = 1'b1;
      repeat (8) step();
      check("held_level", 32'(en_level), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midrst_level", 32'(en_level), 32'(0));
      check("midrst_pulse", 32'(en_pulse), 32'(0));
      check("midrst_data",  32'(data_q),   32'(0));
      check("midrst_busy",  32'(busy),     32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      expect_pulse_at6("post_rst");

      // Reset while ARMING discards the partial count.
      btn_in = 1'b0;
      repeat (8) step();
      check("idle_again", 32'(en_level), 32'(0));
      btn_in = 1'b1;
      repeat (4) step();
      check("arming_busy", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arm_rst_busy",  32'(busy),     32'(0));
      check("arm_rst_pulse", 32'(en_pulse), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expect_pulse_at6("arm_rst");
      btn_in = 1'b0;
      repeat (10) step();

      // Hold 30 cycles past acceptance.
      data_in = 8'h11;
      btn_in  = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (en_pulse) found = 1'b1;
      end
      check("ar_accept_seen", 32'(found), 32'(1));
      check("ar_accept_data", 32'(data_q), 32'(8'h11));
      for (off = 1; off <= 30; off++) begin
         if (off == 3) data_in = 8'h22;
         step();
         check($sformatf("ar_pulse_off%0d", off), 32'(en_pulse),
               32'(AR && (off % (R + 1) == 0)));
      end
      check("ar_level", 32'(en_level), 32'(1));
      check("ar_data",  32'(data_q),   32'(AR ? 8'h22 : 8'h11));
      btn_in = 1'b0;
      repeat (10) step();

      // Random activity against the model.
      run_left = 0;
      cur      = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (run_left == 0) begin
            cur      = ~cur;
            run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(5, 14));
         end
         btn_in = cur;
         run_left--;
         if ($urandom_range(0, 1) == 1) data_in = W'($urandom);
         step();
         check("rnd_level", 32'(en_level), 32'(m.lvl));
         check("rnd_pulse", 32'(en_pulse), 32'(m.pulse));
         check("rnd_data",  32'(data_q),   32'(m.dq));
         check("rnd_busy",  32'(busy),     32'(m.run != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
